timer_ctrl: RTL and testbench

Central sequencing controller for the hour:minute down-counting timer. It replaces the pair of independent start/pause toggle FSMs with one mode FSM. It holds the BCD preset registers and issues load and decrement enables to the hour/minute counter datapath. It also raises the alarm when the count expires. It sits between the debounce/onepulse front end and the minute/hour counter chain.

---
 rtl/timer_ctrl.sv | 164 ++++++++++++++++
 tb/tb_timer_ctrl.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/timer_ctrl.sv
// timer_ctrl -- sequencing controller for the hour:minute down-counting timer.
//
// One mode FSM (IDLE/SET/RUN/PAUSE/DONE) holds the BCD preset registers,
// issues load and decrement enables to the counter datapath and raises the
// alarm when the count expires.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   tick                one-cycle count-rate strobe
//   start_p, pause_p    one-pulse start/stop and pause/resume buttons
//   setting             level switch requesting preset edit mode
//   inc_min_p           one-pulse preset-minute increment (SET only)
//   inc_hour_p          one-pulse preset-hour increment (SET only)
//   zero                datapath flag: count is 00:00
//   preset_*_one/_ten   BCD preset digits
//   load                one-cycle pulse: datapath copies the preset
//   dec_en              combinational decrement strobe (RUN & tick & ~zero)
//   state               IDLE=0, SET=1, RUN=2, PAUSE=3, DONE=4
//   alarm               expiry indication
//
// Optional feature: define TIMER_CTRL_AUTORELOAD_EN to reload the preset and
// restart counting once the alarm period in DONE has elapsed.

module timer_ctrl #(
    parameter int MAX_HOUR    = 23,
    parameter int MAX_MIN     = 59,
    parameter int ALARM_TICKS = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick,
    input  logic       start_p,
    input  logic       pause_p,
    input  logic       setting,
    input  logic       inc_min_p,
    input  logic       inc_hour_p,
    input  logic       zero,
    output logic [3:0] preset_min_one,
    output logic [3:0] preset_min_ten,
    output logic [3:0] preset_hour_one,
    output logic [3:0] preset_hour_ten,
    output logic       load,
    output logic       dec_en,
    output logic [2:0] state,
    output logic       alarm
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SET   = 3'd1,
        RUN   = 3'd2,
        PAUSE = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam int CW = $clog2(ALARM_TICKS + 1);
    localparam logic [CW-1:0] ALARM_MAX = CW'(ALARM_TICKS);

    state_t          st;
    logic [7:0]      min_bcd;
    logic [7:0]      hour_bcd;
    logic [CW-1:0]   alarm_cnt;
    logic [CW-1:0]   alarm_cnt_inc;

    // Two-digit BCD increment that wraps to 00 once the binary value of the
    // digits reaches the limit; no carry leaves the field.
    function automatic logic [7:0] bcd_inc(input logic [7:0] v, input int max);
        int bin;
        bin = int'(v[7:4]) * 10 + int'(v[3:0]);
        if (bin >= max)
            return 8'h00;
        if (v[3:0] == 4'd9)
            return {v[7:4] + 4'd1, 4'd0};
        return {v[7:4], v[3:0] + 4'd1};
    endfunction

    assign state           = st;
    assign preset_min_one  = min_bcd[3:0];
    assign preset_min_ten  = min_bcd[7:4];
    assign preset_hour_one = hour_bcd[3:0];
    assign preset_hour_ten = hour_bcd[7:4];
    assign alarm_cnt_inc   = alarm_cnt + CW'(1);

    // Zero-latency strobe; a tick that coincides with expiry is swallowed.
    assign dec_en = (st == RUN) & tick & ~zero;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st        <= IDLE;
            min_bcd   <= 8'h00;
            hour_bcd  <= 8'h00;
            load      <= 1'b0;
            alarm     <= 1'b0;
            alarm_cnt <= '0;
        end else begin
            load <= 1'b0;
            case (st)
                IDLE: begin
                    if (setting)
                        st <= SET;
                    else if (start_p && !zero)
                        st <= RUN;
                end
                SET: begin
                    if (inc_min_p)
                        min_bcd <= bcd_inc(min_bcd, MAX_MIN);
                    if (inc_hour_p)
                        hour_bcd <= bcd_inc(hour_bcd, MAX_HOUR);
                    if (!setting) begin
                        st   <= IDLE;
                        load <= 1'b1;
                    end
                end
                RUN: begin
                    // Expiry wins over both buttons so it is never missed.
                    if (zero) begin
                        st        <= DONE;
                        alarm_cnt <= '0;
                        alarm     <= 1'b1;
                    end else if (start_p) begin
                        st   <= IDLE;
                        load <= 1'b1;
                    end else if (pause_p) begin
                        st <= PAUSE;
                    end
                end
                PAUSE: begin
                    if (start_p) begin
                        st   <= IDLE;
                        load <= 1'b1;
                    end else if (pause_p) begin
                        st <= RUN;
                    end
                end
                DONE: begin
                    if (start_p || pause_p || setting) begin
                        st        <= IDLE;
                        load      <= 1'b1;
                        alarm_cnt <= '0;
                        alarm     <= 1'b0;
                    end
`ifdef TIMER_CTRL_AUTORELOAD_EN
                    else if (alarm_cnt == ALARM_MAX) begin
                        // A 00:00 preset would expire immediately, so park in IDLE.
                        st        <= (min_bcd == 8'h00 && hour_bcd == 8'h00) ? IDLE : RUN;
                        load      <= 1'b1;
                        alarm_cnt <= '0;
                        alarm     <= 1'b0;
                    end
`endif
                    else if (tick && alarm_cnt != ALARM_MAX) begin
                        alarm_cnt <= alarm_cnt_inc;
                        alarm     <= (alarm_cnt_inc < ALARM_MAX);
                    end
                end
                default: begin
                    st    <= IDLE;
                    alarm <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_timer_ctrl.sv
// Self-checking bench for timer_ctrl: each step drives one cycle of inputs,
// queues the outputs expected after the clock edge, and a monitor pops and
// compares them once the edge has happened.

module tb_timer_ctrl;

    localparam logic [6:0] T  = 7'b1000000;
    localparam logic [6:0] ST = 7'b0100000;
    localparam logic [6:0] PA = 7'b0010000;
    localparam logic [6:0] SE = 7'b0001000;
    localparam logic [6:0] IM = 7'b0000100;
    localparam logic [6:0] IH = 7'b0000010;
    localparam logic [6:0] Z  = 7'b0000001;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SET   = 3'd1;
    localparam logic [2:0] S_RUN   = 3'd2;
    localparam logic [2:0] S_PAUSE = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tick = 1'b0, start_p = 1'b0, pause_p = 1'b0, setting = 1'b0;
    logic       inc_min_p = 1'b0, inc_hour_p = 1'b0, zero = 1'b0;
    logic [3:0] preset_min_one, preset_min_ten, preset_hour_one, preset_hour_ten;
    logic       load, dec_en, alarm;
    logic [2:0] state;

    typedef struct packed {
        logic [2:0]  st;
        logic        ld;
        logic        al;
        logic [15:0] pre;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   em = 0;
    int   eh = 0;

    timer_ctrl dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .tick           (tick),
        .start_p        (start_p),
        .pause_p        (pause_p),
        .setting        (setting),
        .inc_min_p      (inc_min_p),
        .inc_hour_p     (inc_hour_p),
        .zero           (zero),
        .preset_min_one (preset_min_one),
        .preset_min_ten (preset_min_ten),
        .preset_hour_one(preset_hour_one),
        .preset_hour_ten(preset_hour_ten),
        .load           (load),
        .dec_en         (dec_en),
        .state          (state),
        .alarm          (alarm)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] pre_of(input int h, input int m);
        return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10)};
    endfunction

    function automatic logic [15:0] dut_pre();
        return {preset_hour_ten, preset_hour_one, preset_min_ten, preset_min_one};
    endfunction

    // Drive one cycle; ed is dec_en for these inputs, the rest are the
    // registered outputs expected after the following rising edge.
    task automatic step(input logic [6:0] in, input logic [2:0] es, input logic el,
                        input logic ea, input logic ed);
        exp_t e;
        @(negedge clk);
        {tick, start_p, pause_p, setting, inc_min_p, inc_hour_p, zero} = in;
        #1;
        check("dec_en", 32'(dec_en), 32'(ed));
        e.st  = es;
        e.ld  = el;
        e.al  = ea;
        e.pre = pre_of(eh, em);
        sb.push_back(e);
        @(posedge clk);
    endtask

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (sb.size() != 0) begin
            e = sb.pop_front();
            check("state",  32'(state),     32'(e.st));
            check("load",   32'(load),      32'(e.ld));
            check("alarm",  32'(alarm),     32'(e.al));
            check("preset", 32'(dut_pre()), 32'(e.pre));
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_state",  32'(state),     32'(S_IDLE));
        check("rst_preset", 32'(dut_pre()), 32'h0);
        check("rst_load",   32'(load),      32'h0);
        check("rst_alarm",  32'(alarm),     32'h0);
        check("rst_dec_en", 32'(dec_en),    32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Preset entry: 02:03, load on first IDLE cycle
        step(SE, S_SET, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin em++; step(SE | IM, S_SET, 0, 0, 0); end
        for (int i = 0; i < 2; i++) begin eh++; step(SE | IH, S_SET, 0, 0, 0); end
        step(SE | ST | PA, S_SET, 0, 0, 0);
        step(0, S_IDLE, 1, 0, 0);
        step(IM | IH, S_IDLE, 0, 0, 0);

        // Wrap behaviour
        step(SE, S_SET, 0, 0, 0);
        for (int i = 0; i < 56; i++) begin em++; step(SE | IM, S_SET, 0, 0, 0); end
        em = 0;
        step(SE | IM, S_SET, 0, 0, 0);
        for (int i = 0; i < 21; i++) begin eh++; step(SE | IH, S_SET, 0, 0, 0); end
        eh = 0;
        step(SE | IH, S_SET, 0, 0, 0);
        em = 1; eh = 1;
        step(SE | IM | IH, S_SET, 0, 0, 0);
        step(0, S_IDLE, 1, 0, 0);

        // RUN / PAUSE decrementing
        step(ST, S_RUN, 0, 0, 0);
        step(SE, S_RUN, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            step(T, S_RUN, 0, 0, 1);
            step(0, S_RUN, 0, 0, 0);
        end
        step(PA, S_PAUSE, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(T, S_PAUSE, 0, 0, 0);
        step(PA, S_RUN, 0, 0, 0);
        step(T, S_RUN, 0, 0, 1);

        // Expiry coincident with tick, alarm for 8 ticks
        step(T | Z, S_DONE, 0, 1, 0);
        for (int i = 1; i <= 8; i++) step(T | Z, S_DONE, 0, (i < 8), 0);
`ifdef TIMER_CTRL_AUTORELOAD_EN
        step(Z, S_RUN, 1, 0, 0);
        step(0, S_RUN, 0, 0, 0);
        step(T, S_RUN, 0, 0, 1);
        step(ST, S_IDLE, 1, 0, 0);
        step(0, S_IDLE, 0, 0, 0);
`else
        step(T | Z, S_DONE, 0, 0, 0);
        step(Z, S_DONE, 0, 0, 0);
        step(ST | Z, S_IDLE, 1, 0, 0);
        step(0, S_IDLE, 0, 0, 0);
`endif

        // Button priority and zero-guarded start
        step(ST, S_RUN, 0, 0, 0);
        step(ST | PA, S_IDLE, 1, 0, 0);
        step(ST | Z, S_IDLE, 0, 0, 0);
        step(ST, S_RUN, 0, 0, 0);
        step(PA, S_PAUSE, 0, 0, 0);
        step(ST, S_IDLE, 1, 0, 0);
        step(ST, S_RUN, 0, 0, 0);
        step(Z, S_DONE, 0, 1, 0);
        step(PA | Z, S_IDLE, 1, 0, 0);

        // Asynchronous reset mid-RUN
        step(ST, S_RUN, 0, 0, 0);
        step(T, S_RUN, 0, 0, 1);
        @(negedge clk);
        tick = 1'b0;
        rst_n = 1'b0;
        #1;
        em = 0; eh = 0;
        check("arst_state",  32'(state),     32'(S_IDLE));
        check("arst_preset", 32'(dut_pre()), 32'h0);
        check("arst_load",   32'(load),      32'h0);
        @(posedge clk);
        #1;
        check("arst_load_edge", 32'(load), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        step(0, S_IDLE, 0, 0, 0);

        @(posedge clk);
        #2;
        check("sb_drained", 32'(sb.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
